// File: rtl/param_mem_pkg.sv
// Shared types and helpers for the param_mem memory block.
package param_mem_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Deepest read-latency pipeline the block is designed for.
    localparam int RD_LAT_MAX = 4;

    // Even parity: stored bit makes the byte plus its parity bit an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/param_mem_rsp_fifo.sv
// Synchronous response FIFO holding {perr, rdata}; count output feeds the request credit.
module param_mem_rsp_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic                       valid,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign valid   = (count != '0);
    assign head    = valid ? entries[rd_ptr] : '0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: storage has no reset; only pointers and count do, and count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/param_mem.sv
// Parametrised single-port memory with valid/ready requests and buffered in-order responses.
// Optional per-byte even parity is enabled by defining MEM_PARITY_EN.
module param_mem
    import param_mem_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AW        = 8,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_perr,
    input  logic            clear_req,
    input  logic            parity_inj,
    output logic            busy_init
);

    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;
    localparam int CW    = $clog2(RSP_DEPTH + RD_LAT + 1);
    localparam int FCW   = $clog2(RSP_DEPTH + 1);

    state_e          state;
    state_e          state_nxt;
    logic [AW-1:0]   init_addr;
    logic            wr_fire;
    logic            rd_fire;
    logic            rsp_pop;
    logic [DW-1:0]   rd_word;
    logic            rd_perr;
    logic            push_v;
    logic [DW:0]     push_d;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   occupancy;
    logic            fifo_valid;
    logic [DW:0]     fifo_head;
    logic [FCW-1:0]  fifo_count;

    assign wr_fire = req_valid && req_ready && req_we;
    assign rd_fire = req_valid && req_ready && !req_we;
    assign rsp_pop = fifo_valid && rsp_ready;

    // ---------------- storage array ----------------
    logic [DW-1:0] mem [DEPTH];

    // Combinational read lets a read accepted right after a write see the new word.
    assign rd_word = mem[req_addr];

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_addr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] rd_par;

    assign rd_par = par[req_addr];

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            par[init_addr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) par[req_addr][i] <= byte_parity(req_wdata[8*i +: 8]) ^ parity_inj;
            end
        end
    end

    // NOTE: default assigned first so the combinational block cannot infer a latch.
    always_comb begin
        rd_perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (byte_parity(rd_word[8*i +: 8]) != rd_par[i]) rd_perr = 1'b1;
        end
    end
`else
    logic unused_parity_inj;

    assign unused_parity_inj = parity_inj;
    assign rd_perr           = 1'b0;
`endif

    // ---------------- read-latency pipeline ----------------
    generate
        if (RD_LAT == 1) begin : g_direct
            assign push_v   = rd_fire;
            assign push_d   = {rd_perr, rd_word};
            assign inflight = '0;
        end else begin : g_pipe
            logic [RD_LAT-2:0] pv;
            logic [DW:0]       pd [RD_LAT-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv <= '0;
                end else begin
                    pv[0] <= rd_fire;
                    for (int i = 1; i < RD_LAT - 1; i++) pv[i] <= pv[i-1];
                end
            end

            // Payload follows the valid bits; an unset valid makes a stale payload harmless.
            always_ff @(posedge clk) begin
                if (rd_fire) pd[0] <= {rd_perr, rd_word};
                for (int i = 1; i < RD_LAT - 1; i++) pd[i] <= pd[i-1];
            end

            always_comb begin
                inflight = '0;
                for (int i = 0; i < RD_LAT - 1; i++) inflight = inflight + CW'(pv[i]);
            end

            assign push_v = pv[RD_LAT-2];
            assign push_d = pd[RD_LAT-2];
        end
    endgenerate

    // ---------------- response buffer ----------------
    param_mem_rsp_fifo #(
        .W     (DW + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_v),
        .push_data (push_d),
        .pop       (rsp_pop),
        .valid     (fifo_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign rsp_valid = fifo_valid;
    assign rsp_perr  = fifo_head[DW];
    assign rsp_rdata = fifo_head[DW-1:0];

    // A pop this cycle frees its slot immediately, which sustains one read per cycle.
    assign occupancy = inflight + CW'(fifo_count) - CW'(rsp_pop);
    assign req_ready = (state == RUN) && (occupancy < CW'(RSP_DEPTH));
    assign busy_init = (state == INIT);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state     <= state_nxt;
            init_addr <= (state == INIT) ? init_addr + AW'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_addr == '1) state_nxt = RUN;
            RUN:     if (clear_req) state_nxt = DRAIN;
            DRAIN:   if ((inflight == '0) && !fifo_valid) state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

endmodule

// File: tb/tb_param_mem.sv
// Self-checking bench for param_mem: directed scenarios plus randomized traffic against a
// word-level reference model with a response scoreboard. Define MEM_PARITY_EN to match the DUT.
module tb_param_mem;

    localparam int DW        = 16;
    localparam int AW        = 8;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;
    localparam int DEPTH     = 2 ** AW;
    localparam int TIMEOUT   = 2000;
`ifdef MEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_perr;
    logic          clear_req = 1'b0;
    logic          parity_inj = 1'b0;
    logic          busy_init;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit exact_mode = 1'b0;
    bit rand_mode = 1'b0;

    param_mem #(
        .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_perr(rsp_perr), .clear_req(clear_req), .parity_inj(parity_inj),
        .busy_init(busy_init)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: word contents plus a mask of bytes written with injected parity.
    logic [DW-1:0] model_mem [DEPTH];
    logic [1:0]    model_bad [DEPTH];

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int            acc;
        bit            exact;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_zero();
        for (int a = 0; a < DEPTH; a++) begin
            model_mem[a] = '0;
            model_bad[a] = '0;
        end
    endtask

    // Issue one request starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] be, input bit inj);
        int w = 0;
        exp_t e;
        if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        parity_inj = inj;
        forever begin
            @(negedge clk);
            if (req_ready || w >= TIMEOUT) break;
            w++;
            @(posedge clk); #1;
            if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (!req_ready) begin
            check("req_accept_timeout", {31'b0, req_ready}, 32'd1);
        end else if (we) begin
            for (int i = 0; i < 2; i++) begin
                if (be[i]) begin
                    model_mem[a][8*i +: 8] = d[8*i +: 8];
                    model_bad[a][i] = inj;
                end
            end
        end else begin
            e.data  = model_mem[a];
            e.perr  = PAR_EN && (model_bad[a] != 2'b00);
            e.acc   = cyc;
            e.exact = exact_mode;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; parity_inj = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Called at a negedge; counts consecutive negedges with busy_init high.
    task automatic count_init(output int n);
        n = 0;
        while (busy_init && n < 1000) begin
            if (req_ready) check("ready_during_init", {31'b0, req_ready}, 32'd0);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain_sb();
        int w = 0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("sb_drained", sb.size(), 32'd0);
    endtask

    // Response monitor: order, data, parity flag, latency and hold-while-stalled.
    bit            head_seen = 1'b0;
    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_p;
    exp_t          cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            head_seen = 1'b0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", {31'b0, rsp_valid}, 32'd1);
                check("hold_rdata", {16'b0, rsp_rdata}, {16'b0, hold_d});
                check("hold_perr", {31'b0, rsp_perr}, {31'b0, hold_p});
            end
            hold_pend = 1'b0;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    cur = sb[0];
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        if (cur.exact) check("rsp_latency", cyc - cur.acc, RD_LAT);
                        else check("rsp_not_early", {31'b0, (cyc - cur.acc) >= RD_LAT}, 32'd1);
                    end
                    if (rsp_ready) begin
                        check("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, cur.data});
                        check("rsp_perr", {31'b0, rsp_perr}, {31'b0, cur.perr});
                        void'(sb.pop_front());
                        head_seen = 1'b0;
                    end else begin
                        hold_pend = 1'b1;
                        hold_d = rsp_rdata;
                        hold_p = rsp_perr;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int bad;
        int t0;
        model_zero();

        // 1: reset values, then exactly DEPTH cycles of init sweep
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_init", {31'b0, busy_init}, 32'd1);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'b0, rsp_rdata}, 32'd0);
        check("rst_rsp_perr", {31'b0, rsp_perr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        count_init(n);
        check("init_cycles", n, DEPTH);
        @(posedge clk); #1;
        do_req(1'b0, 8'h10, '0, 2'b00, 1'b0);
        drain_sb();

        // 2: writes then reads, exact read latency with an idle response path
        exact_mode = 1'b1;
        do_req(1'b1, 8'h10, 16'h1234, 2'b11, 1'b0);
        do_req(1'b1, 8'h20, 16'hABCD, 2'b11, 1'b0);
        do_req(1'b0, 8'h10, '0, 2'b00, 1'b0);
        do_req(1'b0, 8'h20, '0, 2'b00, 1'b0);
        drain_sb();
        // read immediately after write to the same word
        do_req(1'b1, 8'h55, 16'h0F0F, 2'b11, 1'b0);
        do_req(1'b0, 8'h55, '0, 2'b00, 1'b0);
        drain_sb();
        exact_mode = 1'b0;

        // 3: byte enables, including be=0 as a no-op
        do_req(1'b1, 8'h30, 16'hFFFF, 2'b11, 1'b0);
        do_req(1'b1, 8'h30, 16'h0012, 2'b01, 1'b0);
        do_req(1'b1, 8'h30, 16'h3400, 2'b00, 1'b0);
        do_req(1'b0, 8'h30, '0, 2'b00, 1'b0);
        do_req(1'b1, 8'h31, 16'hAB00, 2'b10, 1'b0);
        do_req(1'b0, 8'h31, '0, 2'b00, 1'b0);
        drain_sb();

        // 4: back-pressure, credit exhaustion after RSP_DEPTH reads
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) do_req(1'b0, AW'(i * 16), '0, 2'b00, 1'b0);
        @(negedge clk);
        check("credit_full_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        bad = 0;
        fork
            do_req(1'b0, 8'h50, '0, 2'b00, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (req_ready) bad++;
                end
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        check("credit_stall_held", bad, 32'd0);
        drain_sb();

        // full throughput: one read accepted per cycle with rsp_ready high
        t0 = cyc;
        for (int i = 0; i < 16; i++) do_req(1'b0, AW'(i), '0, 2'b00, 1'b0);
        check("throughput_cycles", cyc - t0, 32'd16);
        drain_sb();

        // 5: clear with reads outstanding, drain, re-init, then reset mid-sweep
        rsp_ready = 1'b0;
        do_req(1'b0, 8'h10, '0, 2'b00, 1'b0);
        do_req(1'b0, 8'h20, '0, 2'b00, 1'b0);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_ready || busy_init) bad++;
        end
        check("drain_holds", bad, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!busy_init && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("drain_to_init", {31'b0, busy_init}, 32'd1);
        check("drain_sb_empty", sb.size(), 32'd0);
        model_zero();
        count_init(n);
        check("reinit_cycles", n, DEPTH);
        @(posedge clk); #1;
        do_req(1'b0, 8'h20, '0, 2'b00, 1'b0);
        drain_sb();
        // clear_req is ignored outside RUN: pulse it mid-sweep, then reset mid-sweep
        do_req(1'b1, 8'h20, 16'h7777, 2'b11, 1'b0);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        @(negedge clk);
        while (!busy_init && n < 2000) @(negedge clk);
        repeat (100) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midinit_rst_busy", {31'b0, busy_init}, 32'd1);
        check("midinit_rst_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_zero();
        @(negedge clk);
        count_init(n);
        check("restart_init_cycles", n, DEPTH);
        @(posedge clk); #1;
        do_req(1'b0, 8'h20, '0, 2'b00, 1'b0);
        drain_sb();

        // 6: parity injection and clean rewrite
        do_req(1'b1, 8'h40, 16'h5A5A, 2'b11, 1'b1);
        do_req(1'b0, 8'h40, '0, 2'b00, 1'b0);
        do_req(1'b1, 8'h40, 16'h5A5A, 2'b11, 1'b0);
        do_req(1'b0, 8'h40, '0, 2'b00, 1'b0);
        do_req(1'b1, 8'h41, 16'h1357, 2'b11, 1'b0);
        do_req(1'b1, 8'h41, 16'h00C3, 2'b01, 1'b1);
        do_req(1'b0, 8'h41, '0, 2'b00, 1'b0);
        do_req(1'b1, 8'h41, 16'h9900, 2'b10, 1'b0);
        do_req(1'b0, 8'h41, '0, 2'b00, 1'b0);
        drain_sb();

        // 7: randomized mix with random response back-pressure
        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                do_req(1'b1, a, DW'($urandom), 2'($urandom), $urandom_range(0, 7) == 0);
            else
                do_req(1'b0, a, '0, 2'b00, 1'b0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rand_mode = 1'b0;
        drain_sb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
